// File: rtl/sliding_window_sequencer_if.sv
// sliding_window_sequencer_if
//   Groups the frame-control, pixel-handshake and window-tag signals of the
//   sliding window sequencer into one bundle.
//
//   master modport : frame controller / pixel source side (drives start,
//                    config and pix_valid, observes everything else)
//   slave modport  : the sequencer itself
//
//   Signals:
//     start           begin a frame (sampled only while idle)
//     cfg_row_length  pixels per row, latched on an accepted start
//     cfg_num_rows    rows per frame, latched on an accepted start
//     pix_valid       upstream pixel present
//     pix_ready       sequencer accepts a pixel this cycle
//     win_reset       one-cycle sync flush for the SlidingWindow datapath
//     win_in_valid    in_valid for the SlidingWindow datapath
//     r_row_length    latched row length for the SlidingWindow datapath
//     win_valid       window holds a complete in-frame neighbourhood
//     win_x / win_y   window top-left coordinate
//     busy            frame in progress
//     done            one-cycle end-of-frame pulse
//     cfg_err         illegal configuration flag (checked builds only)
interface sliding_window_sequencer_if #(
  parameter int COORD_BITS = 4
);
  logic                  start;
  logic [COORD_BITS:0]   cfg_row_length;
  logic [COORD_BITS:0]   cfg_num_rows;
  logic                  pix_valid;
  logic                  pix_ready;
  logic                  win_reset;
  logic                  win_in_valid;
  logic [COORD_BITS:0]   r_row_length;
  logic                  win_valid;
  logic [COORD_BITS-1:0] win_x;
  logic [COORD_BITS-1:0] win_y;
  logic                  busy;
  logic                  done;
  logic                  cfg_err;

  modport master (
    output start, cfg_row_length, cfg_num_rows, pix_valid,
    input  pix_ready, win_reset, win_in_valid, r_row_length,
           win_valid, win_x, win_y, busy, done, cfg_err
  );

  modport slave (
    input  start, cfg_row_length, cfg_num_rows, pix_valid,
    output pix_ready, win_reset, win_in_valid, r_row_length,
           win_valid, win_x, win_y, busy, done, cfg_err
  );
endinterface

// File: rtl/sliding_window_sequencer.sv
// sliding_window_sequencer
//   Frame-level controller for the SlidingWindow datapath. A start command
//   latches the frame geometry, a one-cycle FLUSH resets the window, then the
//   upstream pixel stream is gated into the window while a raster position is
//   tracked. One cycle after each accepted pixel, win_valid reports whether
//   the window now holds a complete in-frame neighbourhood, tagged with its
//   top-left coordinate (win_x, win_y).
//
//   Ports:
//     clk    system clock
//     reset  asynchronous, active-low reset
//     bus    sliding_window_sequencer_if.slave (start/config, pixel
//            handshake, window control and window tag outputs)
//
//   Build option:
//     SLIDING_WINDOW_SEQ_CFG_CHECK_EN  when defined, a start with an illegal
//     geometry skips the frame (IDLE -> DONE) and raises a sticky cfg_err.
//     When undefined, cfg_err is tied low and no check is made.
module sliding_window_sequencer #(
  parameter int WINDOW_NUM_ROWS = 2,
  parameter int WINDOW_NUM_COLS = 2,
  parameter int MAX_ROW_LENGTH  = 16,
  parameter int COORD_BITS      = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  sliding_window_sequencer_if.slave      bus
);

  typedef enum logic [1:0] {IDLE, FLUSH, STREAM, DONE} state_t;

  localparam logic [COORD_BITS-1:0] CNT_ONE   = COORD_BITS'(1);
  localparam logic [COORD_BITS:0]   CFG_ONE   = (COORD_BITS+1)'(1);
  localparam logic [COORD_BITS-1:0] COL_OFF   = COORD_BITS'(WINDOW_NUM_COLS - 1);
  localparam logic [COORD_BITS-1:0] ROW_OFF   = COORD_BITS'(WINDOW_NUM_ROWS - 1);
  localparam logic [COORD_BITS:0]   ROW_LIMIT = (COORD_BITS+1)'(MAX_ROW_LENGTH);

  state_t                state, state_next;
  logic [COORD_BITS-1:0] x, y;
  logic [COORD_BITS-1:0] win_x_q, win_y_q;
  logic [COORD_BITS:0]   row_length, num_rows;
  logic                  win_valid_q;
  logic                  start_ok;
  logic                  accept;
  logic                  last_col, last_row, frame_end;
  logic                  cfg_ok;
  logic                  pix_ready_c, win_reset_c, busy_c, done_c;

  assign start_ok = (state == IDLE) && bus.start;
  assign accept   = (state == STREAM) && bus.pix_valid;

  // The second term caps a row at MAX_ROW_LENGTH so an unchecked bad length
  // (e.g. 0) cannot leave x running without ever closing a row.
  assign last_col  = ({1'b0, x} == row_length - CFG_ONE) ||
                     ({1'b0, x} == ROW_LIMIT - CFG_ONE);
  assign last_row  = ({1'b0, y} == num_rows - CFG_ONE);
  assign frame_end = accept && last_col && last_row;

`ifdef SLIDING_WINDOW_SEQ_CFG_CHECK_EN
  localparam logic [COORD_BITS:0] MIN_LEN  = (COORD_BITS+1)'(WINDOW_NUM_COLS);
  localparam logic [COORD_BITS:0] MIN_ROWS = (COORD_BITS+1)'(WINDOW_NUM_ROWS);
  localparam logic [COORD_BITS:0] MAX_ROWS = (COORD_BITS+1)'(2**COORD_BITS);

  logic cfg_err_q;

  assign cfg_ok = (bus.cfg_row_length >= MIN_LEN)  && (bus.cfg_row_length <= ROW_LIMIT) &&
                  (bus.cfg_num_rows   >= MIN_ROWS) && (bus.cfg_num_rows   <= MAX_ROWS);

  // cfg_err reflects the most recently accepted start and stays set until
  // the next accepted start re-evaluates it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cfg_err_q <= 1'b0;
    end else if (start_ok) begin
      cfg_err_q <= !cfg_ok;
    end
  end

  assign bus.cfg_err = cfg_err_q;
`else
  assign cfg_ok      = 1'b1;
  assign bus.cfg_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state plus the purely state-decoded outputs. pix_ready is a direct
  // decode so a pixel and its in_valid reach the window in the same cycle.
  always_comb begin
    state_next  = state;
    pix_ready_c = 1'b0;
    win_reset_c = 1'b0;
    busy_c      = 1'b1;
    done_c      = 1'b0;
    case (state)
      IDLE: begin
        busy_c = 1'b0;
        if (bus.start) begin
          state_next = cfg_ok ? FLUSH : DONE;
        end
      end
      FLUSH: begin
        win_reset_c = 1'b1;
        state_next  = STREAM;
      end
      STREAM: begin
        pix_ready_c = 1'b1;
        if (frame_end) begin
          state_next = DONE;
        end
      end
      DONE: begin
        done_c     = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Geometry latch, raster counters and the registered window tag. The tag
  // describes the pixel accepted on the previous cycle, matching the
  // registered output of the SlidingWindow datapath.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      row_length  <= '0;
      num_rows    <= '0;
      x           <= '0;
      y           <= '0;
      win_valid_q <= 1'b0;
      win_x_q     <= '0;
      win_y_q     <= '0;
    end else begin
      win_valid_q <= 1'b0;
      if (start_ok) begin
        row_length <= bus.cfg_row_length;
        num_rows   <= bus.cfg_num_rows;
        x          <= '0;
        y          <= '0;
      end
      if (accept) begin
        if (last_col) begin
          x <= '0;
          y <= y + CNT_ONE;
        end else begin
          x <= x + CNT_ONE;
        end
        win_valid_q <= (x >= COL_OFF) && (y >= ROW_OFF);
        win_x_q     <= x - COL_OFF;
        win_y_q     <= y - ROW_OFF;
      end
    end
  end

  assign bus.pix_ready    = pix_ready_c;
  assign bus.win_reset    = win_reset_c;
  assign bus.win_in_valid = bus.pix_valid && pix_ready_c;
  assign bus.r_row_length = row_length;
  assign bus.win_valid    = win_valid_q;
  assign bus.win_x        = win_x_q;
  assign bus.win_y        = win_y_q;
  assign bus.busy         = busy_c;
  assign bus.done         = done_c;

endmodule

// File: doc/sliding_window_sequencer.md
Name: sliding_window_sequencer

Overview:
Frame-level controller for the SlidingWindow datapath.
- On a start command it latches the frame geometry, flushes the window with a one-cycle sync reset, then gates the upstream pixel stream into the window.
- Tracks the raster position and flags each cycle on which the window holds a complete, in-frame neighbourhood, tagged with the window's top-left coordinate.
- Sits between the pixel source (camera/DMA) and the feature-detect stages that consume out_window.

Parameters:
WINDOW_NUM_ROWS, 2, window height in rows (>=1)
WINDOW_NUM_COLS, 2, window width in columns (>=1)
MAX_ROW_LENGTH, 16, largest legal row length, in pixels
COORD_BITS, 4, width of x/y coordinates

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
start  in  1  begin frame; sampled only in IDLE
cfg_row_length  in  COORD_BITS+1  pixels per row; latched on accepted start
cfg_num_rows  in  COORD_BITS+1  rows per frame; latched on accepted start
pix_valid  in  1  upstream pixel present
pix_ready  out  1  sequencer accepts pixel this cycle
win_reset  out  1  sync flush to SlidingWindow.reset
win_in_valid  out  1  to SlidingWindow.in_valid
r_row_length  out  COORD_BITS+1  latched row length, to SlidingWindow.r_row_length
win_valid  out  1  out_window is a complete in-frame window
win_x  out  COORD_BITS  window top-left column
win_y  out  COORD_BITS  window top-left row
busy  out  1  state != IDLE
done  out  1  one-cycle end-of-frame pulse
cfg_err  out  1  illegal config flag (see Optional Feature)

Behaviour:
- Reset (reset low, async):
  - state=IDLE; x, y, win_x, win_y, r_row_length, r_num_rows = 0.
  - pix_ready, win_reset, win_in_valid, win_valid, done, cfg_err = 0.
- States are IDLE, FLUSH, STREAM, DONE.
  - IDLE: start=1 latches cfg_row_length->r_row_length and cfg_num_rows->r_num_rows, clears x and y, then goes to FLUSH next cycle.
  - FLUSH: exactly one cycle; win_reset=1; then STREAM.
  - STREAM: pix_ready=1 (combinational from state). win_in_valid = pix_valid & pix_ready in the same cycle, so the pixel and its in_valid reach SlidingWindow together.
  - DONE: exactly one cycle; done=1; then IDLE.
- Raster counters, on each accepted pixel:
  - If x == r_row_length-1: x<=0 and y<=y+1.
  - Otherwise: x<=x+1.
  - Counters hold while pix_valid=0, so bubbles are allowed anywhere.
  - Accepting the pixel at x=r_row_length-1, y=r_num_rows-1 moves the state to DONE on the next cycle. No further pixels are accepted.
- Window flag:
  - Registered; one cycle after accepting pixel (x,y), win_valid = (x >= WINDOW_NUM_COLS-1) && (y >= WINDOW_NUM_ROWS-1).
  - The same cycle, win_x = x-(WINDOW_NUM_COLS-1) and win_y = y-(WINDOW_NUM_ROWS-1).
  - On any cycle without an acceptance, win_valid=0 and win_x/win_y hold.
  - The 1-cycle latency matches SlidingWindow's registered output. win_valid for the last pixel coincides with done.
- Arithmetic: counters are COORD_BITS wide and compare against the (COORD_BITS+1)-bit config zero-extended. No wrap occurs for legal configs.
- start while busy is ignored. Config inputs are don't-care outside the start cycle.
- Reset mid-frame aborts immediately to IDLE. No done pulse is produced. The next frame is flushed by FLUSH.

Optional Feature:
Macro SLIDING_WINDOW_SEQ_CFG_CHECK_EN.
- Defined:
  - On an accepted start, the config is checked against WINDOW_NUM_COLS <= cfg_row_length <= MAX_ROW_LENGTH and WINDOW_NUM_ROWS <= cfg_num_rows <= 2**COORD_BITS.
  - A failing config goes IDLE->DONE directly: no FLUSH, no pixels accepted, done pulses, and cfg_err=1.
  - cfg_err is sticky until the next accepted start or reset.
- Undefined: no check is made, cfg_err is tied to 0, and illegal configs give unspecified raster behaviour.

Test Plan:
- 12x12 frame, pix_valid held 1:
  - Flow: start -> win_reset for 1 cycle, then 144 pixels accepted.
  - First win_valid 1 cycle after pixel 13, with (win_x,win_y)=(0,0).
  - Totals: 121 win_valid pulses; last at (10,10), coincident with done.
- Same frame, pix_valid toggling 1,0,0 -> 144 acceptances, 121 win_valid; coordinates identical to the continuous case; no win_valid on bubble+1 cycles.
- start pulsed at pixel 50 of a frame -> ignored, frame completes normally, and r_row_length stays at 12 despite cfg_row_length=8 on that cycle.
- reset low at pixel 70 -> all outputs 0 asynchronously and no done. A new 12x12 frame then gives the same 121-window result.
- 4x2 frame (row length 4, 2 rows) with a 2x2 window -> 3 win_valid pulses at (0,0), (1,0), (2,0); done 1 cycle after the 8th acceptance.
- With SLIDING_WINDOW_SEQ_CFG_CHECK_EN, cfg_row_length=1 -> no pix_ready, done after 1 cycle, cfg_err=1. A subsequent legal start clears cfg_err.
